// File: rtl/cla_pkg.sv
// Shared constants and state encoding for the nibble-serial adder sequencer.
package cla_pkg;
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_seq_state_t;
endpackage

// File: rtl/CarryLookAheadAdder4Bit.sv
// Combinational 4-bit carry lookahead adder slice: all carries formed
// directly from generate/propagate terms in two logic levels.
module CarryLookAheadAdder4Bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum  = w_p ^ w_c[3:0];
  assign o_cout = w_c[4];
endmodule

// File: rtl/cla_slice_sequencer.sv
// Nibble-serial NUMBITS adder: one shared 4-bit CLA slice, LS nibble first,
// carry registered between slices, valid/ready on both sides.
module cla_slice_sequencer
  import cla_pkg::*;
#(
  parameter int NUMBITS = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUMBITS-1:0] a_in,
  input  logic [NUMBITS-1:0] b_in,
  input  logic               c_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUMBITS-1:0] s_out,
  output logic               c_out,
  output logic               ovf_out,
  output logic               busy
);
  localparam int N  = NUMBITS / SLICE_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((NUMBITS % SLICE_W) != 0 || NUMBITS < SLICE_W) begin : g_bad_width
    $error("cla_slice_sequencer: NUMBITS must be a multiple of 4 and >= 4");
  end

  cla_seq_state_t       r_state;
  logic [CW-1:0]        r_k;
  logic [NUMBITS-1:0]   r_a;
  logic [NUMBITS-1:0]   r_b;
  logic                 r_carry;
  logic [NUMBITS-1:0]   r_s;
  logic                 r_cout;
  logic                 r_ovf;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_busy;

  logic [SLICE_W-1:0]   w_a_nib;
  logic [SLICE_W-1:0]   w_b_nib;
  logic [SLICE_W-1:0]   w_sum;
  logic                 w_cout;

  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int i = 0; i < N; i++) begin
      if (r_k == CW'(i)) begin
        w_a_nib = r_a[i*SLICE_W +: SLICE_W];
        w_b_nib = r_b[i*SLICE_W +: SLICE_W];
      end
    end
  end

  CarryLookAheadAdder4Bit u_slice (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Handshake flags are registered alongside the state so every output is a
  // flop; in_ready comes up on the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_s         <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a_in;
            r_b        <= b_in;
            r_carry    <= c_in;
            r_k        <= '0;
            r_state    <= RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        RUN: begin
          for (int i = 0; i < N; i++) begin
            if (r_k == CW'(i)) r_s[i*SLICE_W +: SLICE_W] <= w_sum;
          end
          r_carry <= w_cout;
          r_k     <= r_k + 1'b1;
          if (r_k == LAST) begin
            r_cout      <= w_cout;
            r_ovf       <= (r_a[NUMBITS-1] ~^ r_b[NUMBITS-1]) & (r_a[NUMBITS-1] ^ w_sum[SLICE_W-1]);
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign s_out     = r_s;
  assign c_out     = r_cout;
  assign ovf_out   = r_ovf;
  assign busy      = r_busy;
endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Bench for cla_slice_sequencer: directed vectors plus an arithmetic model
// checked every cycle; extra instances at NUMBITS 4 and 32 run back-to-back.
module tb_cla_slice_sequencer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a_in, b_in, s_out;
  logic        c_in, c_out, ovf_out, busy;

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;
  bit edge_ok = 0;
  bit go = 0;
  bit b2b = 0;

  always #5 clk = ~clk;

  cla_slice_sequencer #(.NUMBITS(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .out_valid(out_valid),
    .out_ready(out_ready), .s_out(s_out), .c_out(c_out), .ovf_out(ovf_out),
    .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: {ovf, c_out, s_out} from plain integer addition and sign rules.
  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] t;
    logic        ovf;
    t   = {1'b0, a} + {1'b0, b} + {16'd0, c};
    ovf = (a[15] == b[15]) && (t[15] != a[15]);
    return {ovf, t};
  endfunction

  always @(posedge clk) begin
    cyc++;
    edge_ok = reset_n;
  end

  logic [17:0] q16[$];
  bit pend = 0;
  int acc16 = 0;
  int prev16 = -1;

  always @(negedge clk) begin
    if (!reset_n) begin
      pend = 0;
      q16.delete();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_s_out", s_out, 0);
      chk("rst_c_out", c_out, 0);
      chk("rst_ovf_out", ovf_out, 0);
    end else begin
      chk("in_ready", in_ready, edge_ok && !pend);
      chk("busy", busy, pend);
      chk("out_valid", out_valid, pend && (cyc >= acc16 + 1 + 4));
      if (out_valid) begin
        if (q16.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          chk("model_s_out", s_out, q16[0][15:0]);
          chk("model_c_out", c_out, q16[0][16]);
          chk("model_ovf", ovf_out, q16[0][17]);
          if (out_ready) begin
            void'(q16.pop_front());
            pend = 0;
          end
        end
      end
      if (in_valid && in_ready) begin
        if (b2b && prev16 >= 0) chk("period16", cyc - prev16, 6);
        prev16 = cyc;
        acc16  = cyc;
        q16.push_back(model16(a_in, b_in, c_in));
        pend = 1;
      end
    end
  end

  // Back-to-back instances at other widths, each with its own scoreboard.
  for (genvar g = 0; g < 2; g++) begin : g_b2b
    localparam int W  = (g == 0) ? 4 : 32;
    localparam int NS = W / 4;
    logic         iv, ir, ov, co, ovf, bz, ci;
    logic [W-1:0] a, b, s;
    logic [W:0]   mt;
    logic [W+1:0] q[$];
    logic [W+1:0] e;
    int acc = -1;
    int n;
    bit done = 0;

    cla_slice_sequencer #(.NUMBITS(W)) u (
      .clk(clk), .reset_n(reset_n), .in_valid(iv), .in_ready(ir),
      .a_in(a), .b_in(b), .c_in(ci), .out_valid(ov), .out_ready(1'b1),
      .s_out(s), .c_out(co), .ovf_out(ovf), .busy(bz)
    );

    initial begin
      iv = 0; a = '0; b = '0; ci = 0;
      wait (go);
      @(posedge clk); #1;
      iv = 1;
      for (int i = 0; i < 500; i++) begin
        a  = W'($urandom);
        b  = W'($urandom);
        ci = 1'($urandom_range(0, 1));
        n = 0;
        while (!ir && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk($sformatf("w%0d_accept_timeout", W), n, 0);
        @(posedge clk); #1;
      end
      iv = 0;
      repeat (NS + 4) @(posedge clk);
      done = 1;
    end

    always @(negedge clk) begin
      if (reset_n && go) begin
        if (ov) begin
          if (q.size() == 0) chk($sformatf("w%0d_unexpected", W), 1, 0);
          else begin
            e = q.pop_front();
            chk($sformatf("w%0d_latency", W), cyc - acc, NS + 1);
            chk($sformatf("w%0d_result", W), {ovf, co, s}, e);
          end
        end
        if (iv && ir) begin
          if (acc >= 0) chk($sformatf("w%0d_period", W), cyc - acc, NS + 2);
          acc = cyc;
          mt  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
          q.push_back({(a[W-1] == b[W-1]) && (mt[W-1] != a[W-1]), mt});
        end
      end
    end
  end

  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic c,
                    input logic [15:0] es, input logic ec, input logic eo);
    int n;
    a_in = a; b_in = b; c_in = c; in_valid = 1;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) chk("op_accept_timeout", n, 0);
    @(posedge clk); #1;
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("op_latency", n, 4);
    chk("op_s_out", s_out, es);
    chk("op_c_out", c_out, ec);
    chk("op_ovf", ovf_out, eo);
    @(posedge clk); #1;
    chk("op_released", out_valid, 0);
  endtask

  initial begin
    int n;
    reset_n = 1; in_valid = 0; out_ready = 1; a_in = '0; b_in = '0; c_in = 0;
    #1 reset_n = 0;
    repeat (2) @(negedge clk);
    chk("init_s_out", s_out, 16'h0000);
    chk("init_in_ready", in_ready, 0);
    #2 reset_n = 1;
    #1 chk("in_ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    chk("in_ready_first_edge", in_ready, 1);

    op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Backpressure: result held while new operands are pulsed at the input.
    out_ready = 0;
    a_in = 16'h0001; b_in = 16'h0002; c_in = 0; in_valid = 1;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("bp_latency", n, 4);
    for (int i = 0; i < 6; i++) begin
      in_valid = (i % 2 == 0);
      a_in = 16'hBEE0 + 16'(i);
      b_in = 16'h1111;
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_s_out", s_out, 16'h0003);
      chk("bp_c_out", c_out, 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    chk("bp_release", out_valid, 0);
    chk("bp_no_accept_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("bp_no_accept_busy", busy, 0);

    // Reset while slice 2 of 0xAAAA + 0x5555 is in the adder.
    a_in = 16'hAAAA; b_in = 16'h5555; c_in = 0; in_valid = 1;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    chk("mid_rst_s_out", s_out, 16'h0000);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(negedge clk); #2 reset_n = 1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    repeat (8) begin
      @(posedge clk); #1;
      chk("aborted_no_out_valid", out_valid, 0);
    end
    op(16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Back-to-back random traffic with both handshakes tied high.
    prev16 = -1;
    b2b = 1;
    go = 1;
    in_valid = 1;
    for (int i = 0; i < 500; i++) begin
      a_in = 16'($urandom);
      b_in = 16'($urandom);
      c_in = 1'($urandom_range(0, 1));
      n = 0;
      while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
      if (n >= 20) chk("b2b16_accept_timeout", n, 0);
      @(posedge clk); #1;
    end
    in_valid = 0;
    repeat (8) @(posedge clk);

    n = 0;
    while (!(g_b2b[0].done && g_b2b[1].done) && n < 20000) begin @(posedge clk); n++; end
    chk("b2b_other_widths_done", n < 20000, 1);
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/cla_slice_sequencer.md
# cla_slice_sequencer

Sequential controller that performs a NUMBITS-wide addition by time-multiplexing a single 4-bit carry lookahead adder slice, one nibble per clock, least-significant first. The carry is registered between slices. It sits in front of the adder datapath as its scheduler. It trades latency for area against the fully parallel n-bit adder. Operands enter and results leave through valid/ready handshakes.

## Interface
- NUMBITS, 16, operand width; must be a multiple of 4 and ≥ 4, otherwise `$error` at elaboration
- clk  input  1  rising-edge clock
- reset_n  input  1  **asynchronous, active-low reset**
- in_valid  input  1  operands valid
- in_ready  output  1  controller can accept operands; high only in IDLE
- a_in  input  NUMBITS  operand A
- b_in  input  NUMBITS  operand B
- c_in  input  1  carry-in
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  consumer accepts result
- s_out  output  NUMBITS  sum
- c_out  output  1  carry-out of the MSB slice
- ovf_out  output  1  signed overflow: carry into MSB xor c_out
- busy  output  1  high in RUN or DONE

## Operation
- N = NUMBITS/4 slices; slice counter width is clog2(N), minimum 1.
- States:
  - IDLE → RUN on in_valid && in_ready. On that edge, capture a_in, b_in and c_in into the operand registers and carry register, and clear the slice counter.
  - RUN: each cycle, feed nibble k of A and B plus the carry register into the 4-bit slice. On the edge:
    - write the sum nibble into s_out[4k+3:4k];
    - load the carry register with the slice carry-out;
    - increment k.
  - RUN → DONE on the edge that processes slice N-1. On that edge:
    - c_out = slice carry-out;
    - ovf_out = (a[MSB] ~^ b[MSB]) & (a[MSB] ^ sum[MSB]).
  - DONE → IDLE on out_valid && out_ready.
- in_valid outside IDLE is ignored. Operands are not buffered.
- No same-cycle turnaround: in_ready stays low in DONE even when out_ready is high. The next op is accepted the cycle after returning to IDLE.
- s_out, c_out and ovf_out hold stable from the DONE entry until the next acceptance. s_out bits not yet written in RUN hold their previous value; consumers sample only when out_valid is high.
- Arithmetic: {c_out, s_out} == a + b + c_in, modulo 2^(NUMBITS+1). Wrap-around is expected: all-ones + 1 gives zero with c_out = 1.
- Reset (any state, including mid-RUN): asynchronous clear of all outputs and registers. State = IDLE, the in-flight op is discarded with no out_valid, s_out = 0, c_out = 0, ovf_out = 0, busy = 0. in_ready = 1 from the first edge after reset_n deasserts.

## Timing
- Acceptance edge = E0. Slice k is registered at edge E0+k+1. out_valid rises after edge E0+N: N cycles of latency (4 for NUMBITS = 16).
- Minimum op period is N+2 cycles: accept, N RUN cycles, one DONE cycle with out_ready = 1.
- All outputs are registered; there is no combinational path from any input to any output except in_ready/out_valid, which derive from state only.
- The 4-bit slice is combinational and must settle within one clk period.

## Structure
- Package `cla_pkg`: SLICE_W = 4 localparam and the state enum `cla_seq_state_t` {IDLE, RUN, DONE}.
- Sub-module: the existing `CarryLookAheadAdder4Bit`, instantiated once as the slice datapath. Everything else is controller logic in this module: FSM, counter, operand/carry/result registers, and the nibble mux.

## Test plan
- NUMBITS = 16: accept 0x1234 + 0x4321 + 1 → out_valid exactly 4 cycles later with s_out = 0x5556, c_out = 0, ovf_out = 0.
- 0xFFFF + 0x0001 + 0 → s_out = 0x0000, c_out = 1, ovf_out = 0. Separately, 0x7FFF + 0x0001 + 0 → s_out = 0x8000, c_out = 0, ovf_out = 1.
- Backpressure: hold out_ready = 0 for 6 cycles in DONE while pulsing in_valid with new operands. Required response:
  - outputs stay stable;
  - in_ready stays 0;
  - the pulsed operands are never accepted;
  - the result is released on the first out_ready = 1.
- Reset mid-RUN: assert reset_n = 0 at slice 2 of 0xAAAA + 0x5555. Required response:
  - all outputs clear immediately (asynchronous);
  - no out_valid for the aborted op;
  - the next op, 0x0F0F + 0xF0F0 + 1, gives s_out = 0x0000, c_out = 1.
- Back-to-back, with out_ready and in_valid tied high: each op is accepted every 6 cycles. Compare 500 random (a, b, c_in) triples against a + b + c_in, and repeat at NUMBITS = 4 (latency 1) and NUMBITS = 32 (latency 8).
